// File: rtl/sel_arb_pkg.sv
// Shared definitions for selector41-based arbiters.
//   arb_state_e : IDLE / GRANT state encoding
//   NUM_SRC     : number of sources sharing one selector41
//   onehot2idx  : one-hot grant -> 2-bit select code (0 for all-zero input)
package sel_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int NUM_SRC = 4;

  function automatic logic [1:0] onehot2idx(input logic [NUM_SRC-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/selector41.sv
// 4:1 selector for 4-bit words.
//   iC0..iC3 : data inputs
//   iS1,iS0  : select code, {iS1,iS0} = index of the routed input
//   oZ       : selected word (combinational)
module selector41 (
  input  logic [3:0] iC0,
  input  logic [3:0] iC1,
  input  logic [3:0] iC2,
  input  logic [3:0] iC3,
  input  logic       iS1,
  input  logic       iS0,
  output logic [3:0] oZ
);

  always_comb begin
    case ({iS1, iS0})
      2'd0:    oZ = iC0;
      2'd1:    oZ = iC1;
      2'd2:    oZ = iC2;
      default: oZ = iC3;
    endcase
  end

endmodule

// File: rtl/selector41_arbiter.sv
// Round-robin scheduler sharing one selector41 among four sources. A grant
// lasts until the source drops its request or MAX_HOLD words have been taken;
// the selected word is captured into a valid/ready output register.
//   iCLK, iRST_N      : clock, asynchronous active-low reset
//   iReq[3:0]         : per-source request
//   iC0..iC3          : source data words
//   iReady            : consumer accepts oZ this cycle
//   oGnt[3:0]         : registered one-hot grant (0 when idle)
//   oAck[3:0]         : combinational, one-hot in the cycle a word is taken
//   oS1,oS0           : registered select code of the granted source
//   oZ, oValid        : registered output word and its valid flag
module selector41_arbiter
  import sel_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4  // legal range 1..15 (4-bit hold counter)
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [3:0] iReq,
  input  logic [3:0] iC0,
  input  logic [3:0] iC1,
  input  logic [3:0] iC2,
  input  logic [3:0] iC3,
  input  logic       iReady,
  output logic [3:0] oGnt,
  output logic [3:0] oAck,
  output logic       oS1,
  output logic       oS0,
  output logic [3:0] oZ,
  output logic       oValid
);

  arb_state_e state_q;
  logic [3:0] gnt_q;
  logic [1:0] s_q, lp_q;
  logic [3:0] hc_q;
  logic [3:0] z_q;
  logic       vld_q;

  logic [3:0] sel_z;
  logic       load, rel;
  logic [1:0] arb_last;
  logic [3:0] gnt_d;
  logic [1:0] s_d;

  // Rotate so the source after 'last' sits at bit 0, take the lowest set
  // bit, then rotate back. 'last' ends up with lowest priority.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] sh;
    logic [7:0] dbl;
    logic [3:0] rot, p;
    sh  = {1'b0, last} + 3'd1;
    dbl = {req, req} >> sh;
    rot = dbl[3:0];
    p   = rot & (~rot + 4'd1);
    dbl = {p, p} << sh;
    return dbl[7:4];
  endfunction

  selector41 u_sel (
    .iC0 (iC0),
    .iC1 (iC1),
    .iC2 (iC2),
    .iC3 (iC3),
    .iS1 (s_q[1]),
    .iS0 (s_q[0]),
    .oZ  (sel_z)
  );

  assign load = (state_q == GRANT) && iReq[s_q] && (!vld_q || iReady);
  assign rel  = (state_q == GRANT) &&
                (!iReq[s_q] || (load && (hc_q == 4'(MAX_HOLD - 1))));

  // In GRANT the current holder is the one that goes to the back of the line
  // on release; lp_q is only the search origin when starting from IDLE.
  assign arb_last = (state_q == GRANT) ? s_q : lp_q;
  assign gnt_d    = rr_pick(iReq, arb_last);
  assign s_d      = onehot2idx(gnt_d);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      lp_q    <= 2'd3;
      hc_q    <= '0;
      z_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      if (load) begin
        z_q   <= sel_z;
        vld_q <= 1'b1;
      end else if (iReady) begin
        vld_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|iReq) begin
            state_q <= GRANT;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            hc_q    <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            lp_q <= s_q;
            hc_q <= '0;
            if (|iReq) begin
              // direct handover; a lone requester re-wins itself here
              gnt_q <= gnt_d;
              s_q   <= s_d;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              s_q     <= '0;
            end
          end else if (load) begin
            hc_q <= hc_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oGnt   = gnt_q;
  assign oAck   = load ? gnt_q : 4'b0000;
  assign oS1    = s_q[1];
  assign oS0    = s_q[0];
  assign oZ     = z_q;
  assign oValid = vld_q;

endmodule

// File: tb/tb_selector41_arbiter.sv
// Randomized + directed stimulus against a queue-based reference model.
// The driver advances the model once per cycle and pushes every word the
// arbiter should take; the monitor pops on each consumer handshake.
module tb_selector41_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] iReq = '0, iC0 = '0, iC1 = '0, iC2 = '0, iC3 = '0;
  logic       iReady = 1'b0;
  logic [3:0] oGnt, oAck, oZ;
  logic       oS1, oS0, oValid;

  always #5 clk = ~clk;

  selector41_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iReq(iReq),
    .iC0(iC0), .iC1(iC1), .iC2(iC2), .iC3(iC3),
    .iReady(iReady), .oGnt(oGnt), .oAck(oAck),
    .oS1(oS1), .oS0(oS0), .oZ(oZ), .oValid(oValid)
  );

  int n_cmp = 0, n_bad = 0;
  logic [3:0] exp_q[$];
  bit chk_en = 0;

  // reference model state
  bit m_busy, m_full;
  int m_g, m_lp, m_hc;
  // expected outputs for the current cycle
  logic [3:0] e_gnt, e_ack;
  logic [1:0] e_s;
  logic       e_vld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (last + i) % 4;
      if (req[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_full = 0; m_g = 0; m_lp = 3; m_hc = 0;
    exp_q.delete();
  endtask

  task automatic model_eval();
    logic [3:0] c [4];
    bit ld, rl;
    c[0] = iC0; c[1] = iC1; c[2] = iC2; c[3] = iC3;
    e_gnt = m_busy ? 4'(1 << m_g) : 4'b0;
    e_s   = m_busy ? 2'(m_g) : 2'b0;
    e_vld = m_full;
    ld    = m_busy && iReq[m_g] && (!m_full || iReady);
    e_ack = ld ? 4'(1 << m_g) : 4'b0;
    if (ld) exp_q.push_back(c[m_g]);
    m_full = ld ? 1'b1 : (iReady ? 1'b0 : m_full);
    if (!m_busy) begin
      if (iReq != 0) begin
        m_g = winner(iReq, m_lp); m_busy = 1; m_hc = 0;
      end
    end else begin
      rl = !iReq[m_g] || (ld && (m_hc + 1 == MAX_HOLD));
      if (ld) m_hc++;
      if (rl) begin
        m_lp = m_g; m_hc = 0;
        if (iReq != 0) m_g = winner(iReq, m_g);
        else m_busy = 0;
      end
    end
  endtask

  // drive one cycle of inputs just after the edge, then advance the model
  task automatic step(input logic [3:0] req, input bit rdy, input bit ramp);
    @(posedge clk); #1;
    iReq = req; iReady = rdy;
    if (ramp) begin
      iC0 = 4'd0; iC1 = 4'd1; iC2 = 4'd2; iC3 = 4'd3;
    end else begin
      iC0 = 4'($urandom_range(0, 15)); iC1 = 4'($urandom_range(0, 15));
      iC2 = 4'($urandom_range(0, 15)); iC3 = 4'($urandom_range(0, 15));
    end
    model_eval();
  endtask

  // monitor: inputs are stable mid-cycle, so all checks happen on negedge
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",   oGnt, e_gnt);
      check("sel",   {oS1, oS0}, e_s);
      check("valid", oValid, e_vld);
      check("ack",   oAck, e_ack);
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL data: got %0d, expected no word (t=%0t)", oZ, $time);
        end else begin
          check("data", oZ, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    check("rst_gnt", oGnt, 0);
    check("rst_sel", {oS1, oS0}, 0);
    check("rst_z", oZ, 0);
    check("rst_valid", oValid, 0);

    step(4'b0000, 1, 0);
    chk_en = 1;

    // round robin with quota
    repeat (36) step(4'b1111, 1, 1);
    repeat (4)  step(4'b0000, 1, 0);
    // early release from source 2, then 3,0,1
    repeat (3)  step(4'b0100, 1, 0);
    repeat (14) step(4'b1011, 1, 0);
    // backpressure
    repeat (3)  step(4'b1111, 1, 0);
    repeat (5)  step(4'b1111, 0, 0);
    repeat (6)  step(4'b1111, 1, 0);
    // lone requester across quota rollovers
    repeat (12) step(4'b0010, 1, 1);
    repeat (4)  step(4'b0000, 1, 0);
    // handover where the request set changes in the release cycle
    repeat (3)  step(4'b0100, 1, 0);
    repeat (8)  step(4'b1001, 1, 0);
    // random traffic
    repeat (300) step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 0);

    // asynchronous reset while a word is held
    repeat (3) step(4'b1111, 0, 0);
    check("pre_rst_valid", oValid, 1);
    @(posedge clk); #3;
    chk_en = 0;
    rst_n  = 1'b0;
    #1;
    check("arst_gnt", oGnt, 0);
    check("arst_sel", {oS1, oS0}, 0);
    check("arst_z", oZ, 0);
    check("arst_valid", oValid, 0);
    check("arst_ack", oAck, 0);
    model_reset();
    iReq = '0; iReady = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step(4'b0001, 1, 0);
    chk_en = 1;
    step(4'b0001, 1, 0);
    check("post_rst_gnt", oGnt, 4'b0001);
    repeat (6) step(4'b0001, 1, 0);

    repeat (8) step(4'b0000, 1, 0);
    check("drained", exp_q.size(), 0);
    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
